// File: rtl/mips_cpu_bus_pkg.sv
// Shared types for the mips_cpu_bus load/store unit: op codes, FSM states, lane count.
package mips_cpu_bus_pkg;

    localparam int BYTE_LANES = 4;

    typedef enum logic [3:0] {
        LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE, BUS, ERR
    } lsu_state_t;

    function automatic logic is_store(lsu_op_t op);
        return op inside {SB, SH, SW};
    endfunction

    // Alignment-sensitive ops drop the LSBs they cannot honour.
    function automatic logic [1:0] eff_offset(lsu_op_t op, logic [1:0] o);
        case (op)
            LH, LHU, SH: return {o[1], 1'b0};
            LW, SW:      return 2'b00;
            default:     return o;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_bus_lsu_extract.sv
// Load result formation: lane select, sign/zero extension, LWL/LWR merge with old rt.
module mips_cpu_bus_lsu_extract
    import mips_cpu_bus_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] rdata
);

    logic [4:0]  sh_lo;
    logic [4:0]  sh_hi;
    logic [31:0] shifted;

    assign sh_lo   = {offset, 3'b000};
    assign sh_hi   = {~offset, 3'b000};   // 8*(3-o)
    assign shifted = readdata >> sh_lo;

    always_comb begin
        rdata = readdata;
        case (lsu_op_t'(op))
            LB:  rdata = {{24{shifted[7]}}, shifted[7:0]};
            LBU: rdata = {24'd0, shifted[7:0]};
            LH:  rdata = {{16{shifted[15]}}, shifted[15:0]};
            LHU: rdata = {16'd0, shifted[15:0]};
            LWL: rdata = (readdata << sh_hi) | (rt_old & ~(32'hFFFF_FFFF << sh_hi));
            LWR: rdata = shifted | (rt_old & ~(32'hFFFF_FFFF >> sh_lo));
            default: rdata = readdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// Load/store unit: one request at a time, word-aligned Avalon transactions with byteenable.
module mips_cpu_bus_lsu
    import mips_cpu_bus_pkg::*;
#(
    parameter logic ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [BYTE_LANES-1:0] byteenable,
    input  logic [31:0] readdata
);

    lsu_state_t state, state_n;
    lsu_op_t    op_in;
    lsu_op_t    op_q;
    logic [1:0] off_in, off_q;
    logic [31:0] rt_old_q;
    logic        misaligned;
    logic [BYTE_LANES-1:0] be_n;
    logic [31:0] wd_n;
    logic [31:0] load_data;

    assign op_in     = lsu_op_t'(req_op);
    assign off_in    = eff_offset(op_in, req_addr[1:0]);
    assign req_ready = (state == IDLE);

    assign misaligned = ALIGN_CHECK &&
        (((op_in inside {LH, LHU, SH}) && req_addr[0]) ||
         ((op_in inside {LW, SW}) && (req_addr[1:0] != 2'b00)));

    // Store data is replicated across lanes; byteenable picks the live ones.
    always_comb begin
        be_n = 4'b1111;
        wd_n = req_wdata;
        case (op_in)
            SB: begin
                be_n = 4'b0001 << off_in;
                wd_n = {4{req_wdata[7:0]}};
            end
            SH: begin
                be_n = 4'b0011 << off_in;
                wd_n = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = misaligned ? ERR : BUS;
            BUS:     if (!waitrequest) state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    mips_cpu_bus_lsu_extract u_extract (
        .op       (op_q),
        .offset   (off_q),
        .readdata (readdata),
        .rt_old   (rt_old_q),
        .rdata    (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q            <= LB;
            off_q           <= 2'b00;
            rt_old_q        <= 32'd0;
            address         <= 32'd0;
            read            <= 1'b0;
            write           <= 1'b0;
            byteenable      <= '0;
            writedata       <= 32'd0;
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            resp_rdata      <= 32'd0;
        end else begin
            resp_valid      <= 1'b0;
            resp_misaligned <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op_q     <= op_in;
                    off_q    <= off_in;
                    rt_old_q <= req_rt_old;
                    if (misaligned) begin
                        // Response is presented during the single ERR cycle.
                        resp_valid      <= 1'b1;
                        resp_misaligned <= 1'b1;
                        resp_rdata      <= 32'd0;
                    end else begin
                        address    <= {req_addr[31:2], 2'b00};
                        read       <= !is_store(op_in);
                        write      <= is_store(op_in);
                        byteenable <= be_n;
                        writedata  <= wd_n;
                    end
                end
                BUS: if (!waitrequest) begin
                    read       <= 1'b0;
                    write      <= 1'b0;
                    resp_valid <= 1'b1;
                    if (read) resp_rdata <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// Randomized self-checking bench for mips_cpu_bus_lsu against a byte-level memory model.
module tb_mips_cpu_bus_lsu;
    import mips_cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [31:0] req_addr = '0, req_wdata = '0, req_rt_old = '0;
    logic        resp_valid, resp_misaligned;
    logic [31:0] resp_rdata;
    logic [31:0] address, writedata, readdata;
    logic        write, read;
    logic        waitrequest = 1'b0;
    logic [3:0]  byteenable;

    int n_checks = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [0:63];
    logic [31:0] slave_mem [0:15];
    logic [31:0] junk = 32'h5A5A_A5A5;
    logic [31:0] prev_rdata;
    logic [31:0] got_rdata;

    always #5 clk = ~clk;

    mips_cpu_bus_lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    // Bus slave: data valid only on the accepting cycle, garbage otherwise.
    assign readdata = (read && !waitrequest) ? slave_mem[address[5:2]] : junk;

    always @(posedge clk) begin
        if (write && !waitrequest && !reset)
            for (int l = 0; l < 4; l++)
                if (byteenable[l]) slave_mem[address[5:2]][8*l +: 8] <= writedata[8*l +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [5:0] a);
        logic [5:0] b;
        b = {a[5:2], 2'b00};
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input lsu_op_t op, input logic [5:0] a, input logic [31:0] rt);
        logic [31:0] w;
        logic [63:0] mask;
        int o;
        w = ref_word(a);
        o = int'(a[1:0]);
        case (op)
            LB:  return {{24{ref_mem[a][7]}}, ref_mem[a]};
            LBU: return {24'd0, ref_mem[a]};
            LH:  return {{16{ref_mem[a+1][7]}}, ref_mem[a+1], ref_mem[a]};
            LHU: return {16'd0, ref_mem[a+1], ref_mem[a]};
            LWL: begin
                mask = (64'd1 << (8*(3-o))) - 64'd1;
                return (w << (8*(3-o))) | (rt & mask[31:0]);
            end
            LWR: return (w >> (8*o)) | (rt & ~(32'hFFFF_FFFF >> (8*o)));
            default: return w;
        endcase
    endfunction

    task automatic set_word(input int idx, input logic [31:0] v);
        slave_mem[idx] = v;
        for (int l = 0; l < 4; l++) ref_mem[4*idx+l] = v[8*l +: 8];
    endtask

    // Runs one request from an IDLE cycle (called #1 after an edge), checks every cycle.
    task automatic do_req(input lsu_op_t op, input logic [5:0] a, input logic [31:0] wd,
                          input logic [31:0] rt, input int stalls);
        logic mis, ld;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
        int o;
        o   = int'(a[1:0]);
        ld  = !(op inside {SB, SH, SW});
        mis = ((op inside {LH, LHU, SH}) && a[0]) || ((op inside {LW, SW}) && a[1:0] != 2'b00);
        exp_be = 4'hF;
        exp_wd = wd;
        if (op == SB) begin exp_be = 4'(1 << o); exp_wd = {4{wd[7:0]}}; end
        if (op == SH) begin exp_be = 4'(3 << o); exp_wd = {2{wd[15:0]}}; end
        exp_rd = ref_load(op, a, rt);

        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = {26'd0, a};
        req_wdata = wd; req_rt_old = rt;
        waitrequest = (stalls > 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = $urandom; req_rt_old = $urandom;

        if (mis) begin
            chk("err_rw", {30'd0, read, write}, 32'd0);
            chk("err_valid", {30'd0, resp_valid, resp_misaligned}, 32'd3);
            chk("err_rdata", resp_rdata, 32'd0);
            chk("err_ready", 32'(req_ready), 32'd0);
            prev_rdata = 32'd0;
            got_rdata  = resp_rdata;
            @(posedge clk); #1;
            chk("err_pulse", {30'd0, resp_valid, read | write}, 32'd0);
            chk("err_back", 32'(req_ready), 32'd1);
            return;
        end

        for (int k = 0; k <= stalls; k++) begin
            chk("bus_ready", 32'(req_ready), 32'd0);
            chk("bus_rw", {30'd0, read, write}, {30'd0, ld, !ld});
            chk("bus_addr", address, {26'd0, a[5:2], 2'b00});
            chk("bus_be", 32'(byteenable), 32'(exp_be));
            if (!ld) chk("bus_wdata", writedata, exp_wd);
            chk("bus_novalid", 32'(resp_valid), 32'd0);
            if (k == stalls) break;
            junk = $urandom;
            @(posedge clk); #1;
            if (k == stalls - 1) waitrequest = 1'b0;
        end
        @(posedge clk); #1;
        chk("done_rw", {30'd0, read, write}, 32'd0);
        chk("resp_valid", {30'd0, resp_valid, resp_misaligned}, 32'd2);
        chk(ld ? "load_rdata" : "store_keeps", resp_rdata, ld ? exp_rd : prev_rdata);
        got_rdata = resp_rdata;
        if (ld) prev_rdata = exp_rd;
        else begin
            ref_mem[a] = wd[7:0];
            if (op == SH) ref_mem[a+1] = wd[15:8];
            if (op == SW) for (int l = 1; l < 4; l++) ref_mem[a+6'(l)] = wd[8*l +: 8];
        end
        @(posedge clk); #1;
        chk("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        set_word(1, 32'h80FF_1234);
        prev_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus", {26'd0, read, write, byteenable}, 32'd0);
        chk("rst_addr", address, 32'd0);
        chk("rst_wdata", writedata, 32'd0);
        chk("rst_resp", {29'd0, resp_valid, resp_misaligned, req_ready}, 32'd1);
        chk("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_req(LB,  6'h7, 0, 0, 0);            chk("tp_lb",  got_rdata, 32'hFFFF_FF80);
        do_req(LBU, 6'h7, 0, 0, 0);            chk("tp_lbu", got_rdata, 32'h0000_0080);
        do_req(LHU, 6'h6, 0, 0, 0);            chk("tp_lhu", got_rdata, 32'h0000_80FF);
        do_req(LH,  6'h6, 0, 0, 0);            chk("tp_lh",  got_rdata, 32'hFFFF_80FF);
        do_req(LW,  6'h4, 0, 0, 0);            chk("tp_lw",  got_rdata, 32'h80FF_1234);
        do_req(LWL, 6'h5, 0, 32'h1122_3344, 0); chk("tp_lwl", got_rdata, 32'h1234_3344);
        do_req(LWR, 6'h5, 0, 32'h1122_3344, 0); chk("tp_lwr", got_rdata, 32'h1180_FF12);
        do_req(SH,  6'h6, 32'h0000_CAFE, 0, 0);
        do_req(LW,  6'h4, 0, 0, 3);            chk("tp_lw_sh", got_rdata, 32'hCAFE_1234);
        do_req(LW,  6'h6, 0, 0, 0);            chk("tp_mis", got_rdata, 32'd0);

        // Reset during a stalled store: bus drops at once, no response, memory untouched.
        req_valid = 1'b1; req_op = SW; req_addr = 32'h8; req_wdata = 32'hDEAD_0001;
        waitrequest = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_sw_write", 32'(write), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_rw", {30'd0, read, write}, 32'd0);
        chk("rst_mid_resp", 32'(resp_valid), 32'd0);
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; waitrequest = 1'b0; prev_rdata = 32'd0;
        @(posedge clk); #1;
        chk("rst_after_resp", 32'(resp_valid), 32'd0);
        chk("rst_after_ready", 32'(req_ready), 32'd1);
        do_req(LW, 6'h8, 0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            lsu_op_t op;
            int st;
            op = lsu_op_t'($urandom_range(0, 9));
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_req(op, 6'($urandom_range(0, 63)), $urandom, $urandom, st);
        end

        for (int i = 0; i < 16; i++) chk("mem_final", slave_mem[i], ref_word(6'(4*i)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_lsu.md
Name: mips_cpu_bus_lsu

Overview:
Load/store unit between the mips_cpu_bus datapath and the Avalon-style memory bus that RAM_32x4096 serves.
- Accepts one memory request at a time from the core.
- Converts byte, half and unaligned-word (lwl/lwr) accesses into word-aligned bus transactions with byteenable.
- Holds the transaction through waitrequest stalls.
- Returns extended or merged load data with a one-cycle completion pulse.

Parameters:
ALIGN_CHECK, 1, when 1 a misaligned lh/lhu/lw/sh/sw is rejected without a bus cycle; when 0 the address LSBs are ignored for those ops.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  core request; sampled only when req_ready=1
req_ready  output  1  high iff FSM is IDLE
req_op  input  4  lsu_op_t: LB LBU LH LHU LW LWL LWR SB SH SW
req_addr  input  32  byte address
req_wdata  input  32  store data (rt)
req_rt_old  input  32  current rt value for LWL/LWR merge
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result; held until next resp_valid
resp_misaligned  output  1  qualifies resp_valid; no bus access was made
address  output  32  word-aligned bus address ({req_addr[31:2],2'b00})
write  output  1  bus write strobe
read  output  1  bus read strobe
waitrequest  input  1  slave stall
writedata  output  32  lane-shifted store data
byteenable  output  4  active lanes
readdata  input  32  bus read data

Behaviour:
- Reset (asynchronous, immediate): state IDLE; read=0, write=0, address=0, writedata=0, byteenable=0, resp_valid=0, resp_rdata=0, resp_misaligned=0.
- Memory is little-endian: byte offset o=addr[1:0] maps to lane o, bits 8o+7:8o.
- States: IDLE, BUS, ERR.
  - IDLE: on an edge with req_valid=1, latch op, offset, wdata and rt_old.
    - Misaligned (ALIGN_CHECK=1 and (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0)): go to ERR.
    - Otherwise: go to BUS and register address, read/write, byteenable and writedata.
  - BUS: read or write held high; address, byteenable and writedata stable.
    - While waitrequest=1: stay in BUS.
    - At the edge where waitrequest=0: for loads, capture readdata; drop read/write; pulse resp_valid in the following cycle; return to IDLE.
  - ERR: one cycle with resp_valid=1, resp_misaligned=1, resp_rdata=0; then IDLE. No read/write is ever asserted on this path.
- Minimum latency with waitrequest=0: request edge, then one BUS cycle, then resp_valid. That is 2 cycles; each stall cycle adds 1.
- Store lanes:
  - SB: byteenable=1<<o; writedata = wdata[7:0] replicated in all lanes.
  - SH: byteenable=0011<<o; writedata = wdata[15:0] replicated in both halves.
  - SW: byteenable=1111; writedata = wdata.
- Loads: byteenable=1111.
  - LB/LBU: lane o, sign-/zero-extended.
  - LH/LHU: lanes o+1:o, sign-/zero-extended.
  - LW: full word.
  - LWL: (readdata << 8(3-o)) | (rt_old & (2^(8(3-o))-1)).
  - LWR: (readdata >> 8o) | (rt_old & ~(32'hFFFFFFFF >> 8o)).
- For stores, resp_rdata keeps its previous value; only resp_valid pulses.
- req_valid while not IDLE is ignored (req_ready=0). The core must hold the request until it sees req_ready.
- Reset asserted mid-BUS drops read/write in the same cycle with no resp_valid. The first request after release starts a fresh transaction.
- readdata is used only on the accepting edge. Values during stall cycles are don't-care.

Decomposition:
- Package mips_cpu_bus_pkg holds lsu_op_t (4-bit enum), lsu_state_t (IDLE/BUS/ERR), and the constant BYTE_LANES=4.
- One combinational sub-module, mips_cpu_bus_lsu_extract, takes op, offset, readdata and rt_old and produces the load result: lane select, extension, LWL/LWR merge.
- Store lane shifting stays inline.

Test Plan:
- Word 0x80FF1234 at 0x4, LB addr 0x7 -> byteenable=1111, address=0x4, resp_rdata=0xFFFFFF80. LBU addr 0x7 -> 0x00000080.
- Same word, LHU 0x6 -> 0x000080FF; LH 0x6 -> 0xFFFF80FF; LW 0x4 -> 0x80FF1234; resp_valid exactly 2 cycles after the request edge.
- SH wdata=0x0000CAFE addr 0x6 -> write=1, byteenable=1100, writedata[31:16]=0xCAFE, address=0x4; subsequent LW 0x4 -> 0xCAFE1234.
- LWL addr 0x5, rt_old=0x11223344, word 0x80FF1234 -> 0x12343344. LWR addr 0x5 -> 0x1180FF12.
- Waitrequest held high 3 cycles on an LW -> read, address and byteenable stable for 4 cycles; a single resp_valid 1 cycle after the waitrequest=0 edge; req_ready=0 throughout.
- LW addr 0x6 -> no read/write, resp_valid=1 and resp_misaligned=1 next cycle. Then reset asserted during a stalled SW -> write=0 immediately, no resp_valid, req_ready=1 after release.
